// File: rtl/rename_recovery_ctrl_if.sv
// Rename-recovery bus: committed-RAT read port plus the RAT restore and
// free-list clear/allocate strobes going to the register rename unit.
interface rename_recovery_ctrl_if #(
  parameter int unsigned PHYS_W = 7,
  parameter int unsigned IDX_W  = 5
);
  logic              crat_rd_en_o;
  logic [1:0]        crat_rd_class_o;
  logic [IDX_W-1:0]  crat_rd_idx_o;
  logic [PHYS_W-1:0] crat_rd_data_i;
  logic              rat_restore_o;
  logic              fl_clear_o;
  logic              fl_alloc_o;
  logic [1:0]        fl_alloc_class_o;
  logic [PHYS_W-1:0] fl_alloc_idx_o;

  modport master (
    output crat_rd_en_o, crat_rd_class_o, crat_rd_idx_o,
    input  crat_rd_data_i,
    output rat_restore_o, fl_clear_o,
    output fl_alloc_o, fl_alloc_class_o, fl_alloc_idx_o
  );

  modport slave (
    input  crat_rd_en_o, crat_rd_class_o, crat_rd_idx_o,
    output crat_rd_data_i,
    input  rat_restore_o, fl_clear_o,
    input  fl_alloc_o, fl_alloc_class_o, fl_alloc_idx_o
  );
endinterface

// File: rtl/rename_recovery_ctrl.sv
// Post-flush rename recovery: restores the speculative RAT, clears the free
// lists, then walks the committed RAT re-marking every mapped register used.
module rename_recovery_ctrl #(
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned NUM_PHYS_INT  = 96,
  parameter int unsigned NUM_PHYS_FP   = 96,
  parameter int unsigned NUM_PHYS_VEC  = 64,
  parameter int unsigned PHYS_W        = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   commit_busy_i,
  rename_recovery_ctrl_if.master rn,
  output logic                   rename_stall_o,
  output logic                   recovery_busy_o,
  output logic                   recovery_done_o,
  output logic                   map_error_o
);
  localparam int unsigned IDX_W = (NUM_ARCH_REGS > 1) ? $clog2(NUM_ARCH_REGS) : 1;
  localparam int unsigned CLS_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARCH_REGS - 1);

  localparam logic [CLS_W-1:0] CLS_INT = 2'd0;
  localparam logic [CLS_W-1:0] CLS_FP  = 2'd1;
  localparam logic [CLS_W-1:0] CLS_VEC = 2'd2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_RESTORE = 3'd2;
  localparam logic [2:0] S_WALK    = 3'd3;
  localparam logic [2:0] S_TAIL    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CLS_W-1:0] cls_q, cls_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [CLS_W-1:0] acls_q, acls_d;
  logic             err_q, err_d;
  logic             rd_en_q, restore_q, busy_q, done_q;

  logic [PHYS_W-1:0] rd_data;
  int unsigned       phys_lim;
  logic              in_range;
  logic              alloc_ok;

  // Range check of the returned mapping against its class's register count
  always_comb begin
    rd_data  = rn.crat_rd_data_i;
    phys_lim = 32'(NUM_PHYS_INT);
    case (acls_q)
      CLS_INT: phys_lim = 32'(NUM_PHYS_INT);
      CLS_FP:  phys_lim = 32'(NUM_PHYS_FP);
      CLS_VEC: phys_lim = 32'(NUM_PHYS_VEC);
      default: phys_lim = 32'd0;
    endcase
    in_range = 32'(rd_data) < phys_lim;
    alloc_ok = vld_q & in_range;
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    idx_d   = idx_q;
    vld_d   = 1'b0;
    acls_d  = cls_q;
    err_d   = err_q | (vld_q & ~in_range);
    case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        if (!commit_busy_i) state_d = S_RESTORE;
      end
      S_RESTORE: begin
        state_d = S_WALK;
        cls_d   = '0;
        idx_d   = '0;
      end
      S_WALK: begin
        vld_d = 1'b1;
        if (cls_q == CLS_VEC && idx_q == LAST_IDX) begin
          state_d = S_TAIL;
          cls_d   = '0;
          idx_d   = '0;
        end else if (idx_q == LAST_IDX) begin
          idx_d = '0;
          cls_d = cls_q + 2'd1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_TAIL:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A flush always restarts from WAIT and drops the in-flight read
    if (flush_i) begin
      state_d = S_WAIT;
      cls_d   = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      acls_q    <= '0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      restore_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      acls_q    <= acls_d;
      err_q     <= err_d;
      rd_en_q   <= (state_d == S_WALK);
      restore_q <= (state_d == S_RESTORE);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign rn.crat_rd_en_o    = rd_en_q;
  assign rn.crat_rd_class_o = cls_q;
  assign rn.crat_rd_idx_o   = idx_q;
  assign rn.rat_restore_o   = restore_q;
  assign rn.fl_clear_o      = restore_q;

  // Read data arrives the cycle after the read; allocate straight from it
  assign rn.fl_alloc_o       = alloc_ok;
  assign rn.fl_alloc_class_o = alloc_ok ? acls_q : '0;
  assign rn.fl_alloc_idx_o   = alloc_ok ? rd_data : '0;

  assign rename_stall_o  = flush_i | busy_q;
  assign recovery_busy_o = busy_q;
  assign recovery_done_o = done_q;
  assign map_error_o     = err_q;
endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// Bench for rename_recovery_ctrl: table of recovery scenarios plus reset
// sequences, with a committed-RAT memory model and an alloc scoreboard.
module tb_rename_recovery_ctrl;
  logic clk;
  logic rst_n;
  logic flush_i;
  logic commit_busy_i;
  logic rename_stall_o;
  logic recovery_busy_o;
  logic recovery_done_o;
  logic map_error_o;

  rename_recovery_ctrl_if #(.PHYS_W(7), .IDX_W(5)) rn ();

  rename_recovery_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .commit_busy_i   (commit_busy_i),
    .rn              (rn),
    .rename_stall_o  (rename_stall_o),
    .recovery_busy_o (recovery_busy_o),
    .recovery_done_o (recovery_done_o),
    .map_error_o     (map_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] cls;
    logic [6:0] phys;
  } alloc_t;

  typedef struct {
    int   b;
    int   rs_at;
    int   pat;
    int   exp_rst;
    int   exp_done;
    int   exp_allocs;
    int   exp_dones;
    logic exp_err;
  } vec_t;

  int     compared   = 0;
  int     mismatched = 0;
  int     alloc_cnt  = 0;
  int     done_cnt   = 0;
  alloc_t sb_q[$];
  logic [6:0] crat [3][32];
  vec_t   tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lim(input int c);
    return (c == 2) ? 64 : 96;
  endfunction

  function automatic void load_pat(input int pat);
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 32; i++) begin
        if (pat == 1) crat[c][i] = (c == 0) ? 7'(95 - i) : (c == 1) ? 7'(40 + i) : 7'(63 - i);
        else          crat[c][i] = 7'(i);
      end
    if (pat == 2) crat[2][7] = 7'd70;
  endfunction

  function automatic void push_all();
    alloc_t e;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 32; i++)
        if (32'(crat[c][i]) < 32'(lim(c))) begin
          e.cls  = 2'(c);
          e.phys = crat[c][i];
          sb_q.push_back(e);
        end
  endfunction

  // Committed RAT: synchronous read, data valid the cycle after the strobe
  always @(posedge clk)
    if (rn.crat_rd_en_o && rn.crat_rd_class_o != 2'd3)
      rn.crat_rd_data_i <= crat[rn.crat_rd_class_o][rn.crat_rd_idx_o];

  always @(negedge clk) begin
    alloc_t e;
    if (rn.fl_alloc_o) begin
      alloc_cnt++;
      check("alloc_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("alloc_class", 32'(rn.fl_alloc_class_o), 32'(e.cls));
        check("alloc_idx", 32'(rn.fl_alloc_idx_o), 32'(e.phys));
      end
    end
    if (recovery_done_o) done_cnt++;
  end

  task automatic check_zero();
    check("z_rd_en", 32'(rn.crat_rd_en_o), 0);
    check("z_rd_class", 32'(rn.crat_rd_class_o), 0);
    check("z_rd_idx", 32'(rn.crat_rd_idx_o), 0);
    check("z_restore", 32'(rn.rat_restore_o), 0);
    check("z_clear", 32'(rn.fl_clear_o), 0);
    check("z_alloc", 32'(rn.fl_alloc_o), 0);
    check("z_alloc_class", 32'(rn.fl_alloc_class_o), 0);
    check("z_alloc_idx", 32'(rn.fl_alloc_idx_o), 0);
    check("z_stall", 32'(rename_stall_o), 0);
    check("z_busy", 32'(recovery_busy_o), 0);
    check("z_done", 32'(recovery_done_o), 0);
    check("z_map_error", 32'(map_error_o), 0);
  endtask

  task automatic run_rec(input vec_t v);
    int   rst_c, done_c, busy_n, a0, d0;
    logic stall0, early, pair_bad, bubble, post_busy, post_stall;
    rst_c = -1; done_c = -1; busy_n = 0;
    stall0 = 1'b0; early = 1'b0; pair_bad = 1'b0; bubble = 1'b0;
    post_busy = 1'b1; post_stall = 1'b1;
    @(posedge clk); #1;
    load_pat(v.pat);
    sb_q.delete();
    push_all();
    a0 = alloc_cnt;
    d0 = done_cnt;
    flush_i = 1'b1;
    commit_busy_i = (v.b > 0);
    for (int c = 0; c < v.exp_done + 40; c++) begin
      @(negedge clk); #1;
      if (c == 0) stall0 = rename_stall_o;
      if (rn.rat_restore_o) rst_c = c;
      if (rn.rat_restore_o != rn.fl_clear_o) pair_bad = 1'b1;
      if (rn.crat_rd_en_o && rst_c < 0) early = 1'b1;
      if (v.rs_at >= 0 && c == v.rs_at + 1) bubble = rn.fl_alloc_o;
      if (recovery_done_o && done_c < 0 && c > v.rs_at) done_c = c;
      if (recovery_busy_o && (done_c < 0 || c == done_c)) busy_n++;
      if (done_c >= 0 && c == done_c + 1) begin
        post_busy  = recovery_busy_o;
        post_stall = rename_stall_o;
        break;
      end
      @(posedge clk); #1;
      flush_i       = (c + 1 == v.rs_at);
      commit_busy_i = (c + 1 < v.b);
      if (v.rs_at >= 0 && c + 1 == v.rs_at + 1) begin
        sb_q.delete();
        push_all();
        a0 = alloc_cnt;
      end
    end
    flush_i = 1'b0;
    commit_busy_i = 1'b0;
    check("stall_in_flush_cycle", 32'(stall0), 1);
    check("restore_cycle", rst_c, v.exp_rst);
    check("done_cycle", done_c, v.exp_done);
    check("done_pulses", done_cnt - d0, v.exp_dones);
    check("alloc_count", alloc_cnt - a0, v.exp_allocs);
    check("sb_leftover", sb_q.size(), 0);
    check("map_error", 32'(map_error_o), 32'(v.exp_err));
    check("read_before_restore", 32'(early), 0);
    check("restore_clear_pair", 32'(pair_bad), 0);
    check("busy_cycles", busy_n, v.exp_done);
    check("idle_busy", 32'(post_busy), 0);
    check("idle_stall", 32'(post_stall), 0);
    if (v.rs_at >= 0) check("restart_bubble", 32'(bubble), 0);
  endtask

  initial begin
    vec_t fin;
    rst_n = 1'b0;
    flush_i = 1'b0;
    commit_busy_i = 1'b0;
    load_pat(0);
    //        b  rs_at pat rst done allocs dones err
    tbl[0] = '{0, -1,  0,  2,  100, 96, 1, 1'b0};
    tbl[1] = '{5, -1,  1,  6,  104, 96, 1, 1'b0};
    tbl[2] = '{1, -1,  0,  2,  100, 96, 1, 1'b0};
    tbl[3] = '{0, 43,  1,  45, 143, 96, 1, 1'b0};
    tbl[4] = '{0, -1,  2,  2,  100, 95, 1, 1'b1};
    tbl[5] = '{3, -1,  0,  4,  102, 96, 1, 1'b1};
    tbl[6] = '{0, 100, 0,  102, 200, 96, 2, 1'b1};
    fin    = '{0, -1,  0,  2,  100, 96, 1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_zero();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) run_rec(tbl[k]);

    // Reset while the walk is reading int index 10
    @(posedge clk); #1;
    load_pat(0);
    sb_q.delete();
    push_all();
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    check("walk_rd_en", 32'(rn.crat_rd_en_o), 1);
    check("walk_rd_class", 32'(rn.crat_rd_class_o), 0);
    check("walk_rd_idx", 32'(rn.crat_rd_idx_o), 10);
    check("pre_reset_map_error", 32'(map_error_o), 1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_zero();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_rec(fin);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
